// File: rtl/jedro_1_mem_arbiter_if.sv
// Bus bundle for jedro_1_mem_arbiter: IFU/LSU request-response channels and the shared memory port.
// slave = arbiter view, master = view of the surrounding requesters and memory.
interface jedro_1_mem_arbiter_if;
    logic [31:0] ifu_req_addr_i;
    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic        ifu_rsp_valid_o;
    logic        ifu_rsp_ready_i;

    logic [31:0] lsu_req_addr_i;
    logic [31:0] lsu_req_data_i;
    logic [3:0]  lsu_req_strobe_i;
    logic        lsu_req_write_i;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic        lsu_rsp_valid_o;
    logic        lsu_rsp_ready_i;

    logic [31:0] rsp_data_o;
    logic        rsp_error_o;

    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_data_o;
    logic [3:0]  mem_req_strobe_o;
    logic        mem_req_write_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_rsp_data_i;
    logic        mem_rsp_error_i;
    logic        mem_rsp_valid_i;
    logic        mem_rsp_ready_o;

    modport slave (
        input  ifu_req_addr_i, ifu_req_valid_i, ifu_rsp_ready_i,
        input  lsu_req_addr_i, lsu_req_data_i, lsu_req_strobe_i, lsu_req_write_i,
        input  lsu_req_valid_i, lsu_rsp_ready_i,
        input  mem_req_ready_i, mem_rsp_data_i, mem_rsp_error_i, mem_rsp_valid_i,
        output ifu_req_ready_o, ifu_rsp_valid_o, lsu_req_ready_o, lsu_rsp_valid_o,
        output rsp_data_o, rsp_error_o,
        output mem_req_addr_o, mem_req_data_o, mem_req_strobe_o, mem_req_write_o,
        output mem_req_valid_o, mem_rsp_ready_o
    );

    modport master (
        output ifu_req_addr_i, ifu_req_valid_i, ifu_rsp_ready_i,
        output lsu_req_addr_i, lsu_req_data_i, lsu_req_strobe_i, lsu_req_write_i,
        output lsu_req_valid_i, lsu_rsp_ready_i,
        output mem_req_ready_i, mem_rsp_data_i, mem_rsp_error_i, mem_rsp_valid_i,
        input  ifu_req_ready_o, ifu_rsp_valid_o, lsu_req_ready_o, lsu_rsp_valid_o,
        input  rsp_data_o, rsp_error_o,
        input  mem_req_addr_o, mem_req_data_o, mem_req_strobe_o, mem_req_write_o,
        input  mem_req_valid_o, mem_rsp_ready_o
    );
endinterface

// File: rtl/jedro_1_mem_arbiter.sv
// Two-requester (IFU/LSU) memory arbiter with grant lock and an in-order owner FIFO for responses.
// Define JEDRO_1_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module jedro_1_mem_arbiter #(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    jedro_1_mem_arbiter_if.slave   bus
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_e;

    owner_e             owner_mem [OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               lock_q;
    owner_e             lock_owner_q;
`ifdef JEDRO_1_ARB_RR_EN
    logic               rr_lsu_q;
`endif

    owner_e             grant;
    owner_e             head;
    logic               can_grant;
    logic               fifo_valid;
    logic               req_fire;
    logic               rsp_fire;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(OUTSTANDING - 1))
            return '0;
        return ptr + PTR_W'(1);
    endfunction

    // Registered count only: a pop in the same cycle must not open a grant.
    assign can_grant  = !rst_i && (count_q < CNT_W'(OUTSTANDING));
    assign fifo_valid = !rst_i && (count_q != '0);
    assign head       = owner_mem[rd_ptr_q];
    assign req_fire   = bus.mem_req_valid_o && bus.mem_req_ready_i;
    assign rsp_fire   = bus.mem_rsp_valid_i && bus.mem_rsp_ready_o;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant = OWNER_LSU;
        if (lock_q) begin
            grant = lock_owner_q;
        end else begin
`ifdef JEDRO_1_ARB_RR_EN
            if (rr_lsu_q)
                grant = bus.lsu_req_valid_i ? OWNER_LSU : OWNER_IFU;
            else
                grant = bus.ifu_req_valid_i ? OWNER_IFU : OWNER_LSU;
`else
            grant = bus.lsu_req_valid_i ? OWNER_LSU : OWNER_IFU;
`endif
        end
    end

    always_comb begin
        bus.mem_req_valid_o  = 1'b0;
        bus.ifu_req_ready_o  = 1'b0;
        bus.lsu_req_ready_o  = 1'b0;
        bus.mem_req_addr_o   = bus.ifu_req_addr_i;
        bus.mem_req_data_o   = '0;
        bus.mem_req_strobe_o = 4'b1111;
        bus.mem_req_write_o  = 1'b0;
        if (grant == OWNER_LSU) begin
            bus.mem_req_addr_o   = bus.lsu_req_addr_i;
            bus.mem_req_data_o   = bus.lsu_req_data_i;
            bus.mem_req_strobe_o = bus.lsu_req_strobe_i;
            bus.mem_req_write_o  = bus.lsu_req_write_i;
        end
        if (can_grant) begin
            if (grant == OWNER_LSU) begin
                bus.mem_req_valid_o = bus.lsu_req_valid_i;
                bus.lsu_req_ready_o = bus.mem_req_ready_i;
            end else begin
                bus.mem_req_valid_o = bus.ifu_req_valid_i;
                bus.ifu_req_ready_o = bus.mem_req_ready_i;
            end
        end
    end

    always_comb begin
        bus.ifu_rsp_valid_o = 1'b0;
        bus.lsu_rsp_valid_o = 1'b0;
        bus.mem_rsp_ready_o = 1'b0;
        bus.rsp_data_o      = bus.mem_rsp_data_i;
        bus.rsp_error_o     = bus.mem_rsp_error_i;
        if (fifo_valid) begin
            if (head == OWNER_LSU) begin
                bus.lsu_rsp_valid_o = bus.mem_rsp_valid_i;
                bus.mem_rsp_ready_o = bus.lsu_rsp_ready_i;
            end else begin
                bus.ifu_rsp_valid_o = bus.mem_rsp_valid_i;
                bus.mem_rsp_ready_o = bus.ifu_rsp_ready_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_LSU;
        end else begin
            lock_q       <= bus.mem_req_valid_o && !bus.mem_req_ready_i;
            lock_owner_q <= grant;
            if (req_fire)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (rsp_fire)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({req_fire, rsp_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: owner storage needs no reset; count/pointers decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (req_fire)
            owner_mem[wr_ptr_q] <= grant;
    end

`ifdef JEDRO_1_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr_lsu_q <= 1'b1;
        else if (req_fire)
            rr_lsu_q <= (grant == OWNER_IFU);
    end
`endif

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Directed self-checking bench for jedro_1_mem_arbiter (OUTSTANDING=2); honours JEDRO_1_ARB_RR_EN.
module tb_jedro_1_mem_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    jedro_1_mem_arbiter_if bus ();

    jedro_1_mem_arbiter #(.OUTSTANDING(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ifu_req_addr_i   = '0;
        bus.ifu_req_valid_i  = 1'b0;
        bus.ifu_rsp_ready_i  = 1'b0;
        bus.lsu_req_addr_i   = '0;
        bus.lsu_req_data_i   = '0;
        bus.lsu_req_strobe_i = '0;
        bus.lsu_req_write_i  = 1'b0;
        bus.lsu_req_valid_i  = 1'b0;
        bus.lsu_rsp_ready_i  = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_rsp_data_i   = '0;
        bus.mem_rsp_error_i  = 1'b0;
        bus.mem_rsp_valid_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr [4];
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();
        repeat (2) @(posedge clk);

        // Reset: every handshake output low even with all inputs asserted
        @(negedge clk);
        bus.ifu_req_valid_i = 1'b1; bus.lsu_req_valid_i = 1'b1;
        bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b1;
        bus.ifu_rsp_ready_i = 1'b1; bus.lsu_rsp_ready_i = 1'b1;
        #1;
        check("rst_mem_req_valid", bus.mem_req_valid_o, 0);
        check("rst_ifu_req_ready", bus.ifu_req_ready_o, 0);
        check("rst_lsu_req_ready", bus.lsu_req_ready_o, 0);
        check("rst_ifu_rsp_valid", bus.ifu_rsp_valid_o, 0);
        check("rst_lsu_rsp_valid", bus.lsu_rsp_valid_o, 0);
        check("rst_mem_rsp_ready", bus.mem_rsp_ready_o, 0);
        @(negedge clk);
        idle();
        rst = 1'b0;

        // IFU-only reads
        @(negedge clk);
        bus.ifu_req_valid_i = 1'b1; bus.ifu_req_addr_i = 32'h8000_0000;
        bus.mem_req_ready_i = 1'b1;
        #1;
        check("ifu0_valid",  bus.mem_req_valid_o, 1);
        check("ifu0_addr",   bus.mem_req_addr_o, 32'h8000_0000);
        check("ifu0_data",   bus.mem_req_data_o, 0);
        check("ifu0_strobe", bus.mem_req_strobe_o, 4'hF);
        check("ifu0_write",  bus.mem_req_write_o, 0);
        check("ifu0_ready",  bus.ifu_req_ready_o, 1);
        check("ifu0_lready", bus.lsu_req_ready_o, 0);
        @(negedge clk);
        bus.ifu_req_addr_i = 32'h8000_0004;
        #1;
        check("ifu1_valid", bus.mem_req_valid_o, 1);
        check("ifu1_addr",  bus.mem_req_addr_o, 32'h8000_0004);

        // Two outstanding: grant blocked even while a response pops this cycle
        @(negedge clk);
        bus.ifu_req_addr_i = 32'h8000_0008;
        bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 32'h13; bus.ifu_rsp_ready_i = 1'b1;
        #1;
        check("full_mem_valid", bus.mem_req_valid_o, 0);
        check("full_ifu_ready", bus.ifu_req_ready_o, 0);
        check("rsp0_data",      bus.rsp_data_o, 32'h13);
        check("rsp0_ifu_valid", bus.ifu_rsp_valid_o, 1);
        check("rsp0_lsu_valid", bus.lsu_rsp_valid_o, 0);
        check("rsp0_mem_ready", bus.mem_rsp_ready_o, 1);
        @(negedge clk);
        bus.mem_rsp_data_i = 32'h93; bus.mem_req_ready_i = 1'b0;
        #1;
        check("rsp1_data",        bus.rsp_data_o, 32'h93);
        check("rsp1_ifu_valid",   bus.ifu_rsp_valid_o, 1);
        check("rsp1_lsu_valid",   bus.lsu_rsp_valid_o, 0);
        check("regrant_valid",    bus.mem_req_valid_o, 1);
        check("regrant_ifu_rdy",  bus.ifu_req_ready_o, 0);
        @(negedge clk);
        idle();
        #1;
        check("drop_mem_valid", bus.mem_req_valid_o, 0);

        // Simultaneous IFU read and LSU store: LSU first, IFU next cycle
        @(negedge clk);
        bus.ifu_req_valid_i = 1'b1; bus.ifu_req_addr_i = 32'h200;
        bus.lsu_req_valid_i = 1'b1; bus.lsu_req_addr_i = 32'h100;
        bus.lsu_req_data_i = 32'hDEAD_BEEF; bus.lsu_req_strobe_i = 4'hF; bus.lsu_req_write_i = 1'b1;
        bus.mem_req_ready_i = 1'b1;
        #1;
        check("both_addr",      bus.mem_req_addr_o, 32'h100);
        check("both_data",      bus.mem_req_data_o, 32'hDEAD_BEEF);
        check("both_write",     bus.mem_req_write_o, 1);
        check("both_lsu_ready", bus.lsu_req_ready_o, 1);
        check("both_ifu_ready", bus.ifu_req_ready_o, 0);
        @(negedge clk);
        bus.lsu_req_valid_i = 1'b0;
        #1;
        check("second_addr",      bus.mem_req_addr_o, 32'h200);
        check("second_write",     bus.mem_req_write_o, 0);
        check("second_ifu_ready", bus.ifu_req_ready_o, 1);

        // Responses return in request order: LSU then IFU (IFU stalls 2 cycles)
        @(negedge clk);
        idle();
        bus.mem_rsp_valid_i = 1'b1; bus.mem_rsp_data_i = 32'hAA; bus.lsu_rsp_ready_i = 1'b1;
        #1;
        check("ord0_lsu_valid", bus.lsu_rsp_valid_o, 1);
        check("ord0_ifu_valid", bus.ifu_rsp_valid_o, 0);
        check("ord0_mem_ready", bus.mem_rsp_ready_o, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_rsp_data_i = 32'hBB;
            #1;
            check("stall_ifu_valid", bus.ifu_rsp_valid_o, 1);
            check("stall_lsu_valid", bus.lsu_rsp_valid_o, 0);
            check("stall_mem_ready", bus.mem_rsp_ready_o, 0);
            check("stall_data",      bus.rsp_data_o, 32'hBB);
        end
        @(negedge clk);
        bus.ifu_rsp_ready_i = 1'b1;
        #1;
        check("unstall_mem_ready", bus.mem_rsp_ready_o, 1);

        // Lock: IFU stalled 3 cycles, LSU arrives in cycle 2 and must wait
        @(negedge clk);
        idle();
        bus.ifu_req_valid_i = 1'b1; bus.ifu_req_addr_i = 32'h300;
        #1;
        check("lock1_addr", bus.mem_req_addr_o, 32'h300);
        @(negedge clk);
        bus.lsu_req_valid_i = 1'b1; bus.lsu_req_addr_i = 32'h400;
        #1;
        check("lock2_addr",      bus.mem_req_addr_o, 32'h300);
        check("lock2_lsu_ready", bus.lsu_req_ready_o, 0);
        @(negedge clk);
        #1;
        check("lock3_addr", bus.mem_req_addr_o, 32'h300);
        @(negedge clk);
        bus.mem_req_ready_i = 1'b1;
        #1;
        check("lock_fire_addr",  bus.mem_req_addr_o, 32'h300);
        check("lock_fire_ready", bus.ifu_req_ready_o, 1);
        @(negedge clk);
        bus.ifu_req_valid_i = 1'b0;
        #1;
        check("after_lock_addr",  bus.mem_req_addr_o, 32'h400);
        check("after_lock_ready", bus.lsu_req_ready_o, 1);

        // Reset mid-transaction with two outstanding and a response pending
        @(negedge clk);
        idle();
        rst = 1'b1;
        bus.ifu_req_valid_i = 1'b1; bus.mem_req_ready_i = 1'b1;
        bus.mem_rsp_valid_i = 1'b1; bus.ifu_rsp_ready_i = 1'b1; bus.lsu_rsp_ready_i = 1'b1;
        #1;
        check("mrst_mem_valid", bus.mem_req_valid_o, 0);
        check("mrst_ifu_ready", bus.ifu_req_ready_o, 0);
        check("mrst_ifu_rsp",   bus.ifu_rsp_valid_o, 0);
        check("mrst_lsu_rsp",   bus.lsu_rsp_valid_o, 0);
        check("mrst_mem_ready", bus.mem_rsp_ready_o, 0);
        @(negedge clk);
        #1;
        check("mrst_count", 32'(dut.count_q), 0);
        rst = 1'b0;
        bus.mem_rsp_valid_i = 1'b0; bus.mem_req_ready_i = 1'b0;
        #1;
        check("post_rst_valid", bus.mem_req_valid_o, 1);
        @(negedge clk);
        idle();

        // Both requesters continuously valid, responses drained every cycle
`ifdef JEDRO_1_ARB_RR_EN
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h600; exp_addr[2] = 32'h500; exp_addr[3] = 32'h600;
`else
        exp_addr[0] = 32'h500; exp_addr[1] = 32'h500; exp_addr[2] = 32'h500; exp_addr[3] = 32'h500;
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.lsu_req_valid_i = 1'b1; bus.lsu_req_addr_i = 32'h500;
            bus.ifu_req_valid_i = 1'b1; bus.ifu_req_addr_i = 32'h600;
            bus.mem_req_ready_i = 1'b1;
            bus.mem_rsp_valid_i = 1'b1; bus.ifu_rsp_ready_i = 1'b1; bus.lsu_rsp_ready_i = 1'b1;
            #1;
            check("stream_addr",  bus.mem_req_addr_o, exp_addr[i]);
            check("stream_valid", bus.mem_req_valid_o, 1);
        end
        @(negedge clk);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
